nop_event_capture: RTL
======================

NOP_EVENT_CAPTURE -- requirements
Module: nop_event_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TERM_CROSS_NUM, default 4, width of termination_all.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_sys  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  writeback stage valid (not frozen).
REQ-006 SHALL have port wb_pc  input  32  writeback PC.
REQ-007 SHALL have port wb_insn  input  32  writeback instruction.
REQ-008 SHALL have port r3  input  32  GPR r3 value at writeback.
REQ-009 SHALL have port supv  input  1  supervisor mode flag.
REQ-010 SHALL have port ev_valid  output  1  event available.
REQ-011 SHALL have port ev_ready  input  1  consumer accepts event.
REQ-012 SHALL have port ev_data  output  nop_event_t  {id[15:0], value[31:0], pc[31:0], supv} (plus timestamp, REQ-030).
REQ-013 SHALL have port ev_dropped  output  16  events lost to full FIFO.
REQ-014 SHALL have port termination  output  1  this core finished and drained.
REQ-015 SHALL have port termination_all  input  TERM_CROSS_NUM  termination of all cores.
REQ-016 SHALL have port all_done  output  1  every core terminated.

Function
REQ-017 Event detect SHALL fire when enable=1, wb_insn[31:16]=16'h1500 and wb_insn[15:0]!=0; id=wb_insn[15:0], value=r3, pc=wb_pc, supv=supv, sampled that cycle.
REQ-018 Detected events SHALL enter the FIFO on the next clk edge; ev_valid SHALL be 1 one cycle after detection at the earliest (latency 1).
REQ-019 Transfer SHALL occur when ev_valid&&ev_ready; ev_data SHALL hold stable while ev_valid&&!ev_ready.
REQ-020 On detect with FIFO full and no pop that cycle, the event SHALL be dropped and ev_dropped incremented, saturating at 16'hFFFF; simultaneous pop and push on a full FIFO SHALL not drop.
REQ-021 State machine SHALL have states ACTIVE, DRAIN, DONE; reset state ACTIVE.
REQ-022 ACTIVE->DRAIN when id=16'h0001 (exit) is enqueued; the exit event itself SHALL be enqueued (it is never dropped: if full, it waits in a one-entry holding register until space frees).
REQ-023 In DRAIN and DONE, new detections SHALL be ignored and not counted as dropped.
REQ-024 DRAIN->DONE when FIFO empty and holding register empty; DONE is terminal until reset.
REQ-025 termination SHALL be 1 exactly in DONE.
REQ-026 all_done SHALL be registered &termination_all (one cycle latency).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit for full/empty distinction.

Reset
REQ-028 On rst_sys: state=ACTIVE, FIFO empty, holding empty, ev_valid=0, ev_data=0, ev_dropped=0, termination=0, all_done=0; reset mid-transfer SHALL discard all queued events.

Configuration
REQ-029 Macro OPTIMSOC_NOP_EVENT_TIMESTAMP_EN SHALL select timestamping.
REQ-030 Defined: a free-running 32-bit cycle counter (reset 0, wraps) SHALL be captured into ev_data.timestamp at detection; undefined: no counter, timestamp field absent from nop_event_t.

Structure
REQ-031 Package nop_event_pkg SHALL hold nop_event_t, NOP_OPCODE_HI=16'h1500, NOP_EXIT=16'h0001, NOP_PUTC=16'h0004, state enum.
REQ-032 FIFO SHALL be sub-module nop_event_fifo (parameterised depth, type via package).

Verification
REQ-033 wb_insn=32'h15000004, r3=32'h41, enable=1, ev_ready=1 -> next cycle ev_valid=1, id=4, value=32'h41, then ev_valid=0.
REQ-034 Same insn with enable=0 -> no event, ev_dropped=0.
REQ-035 ev_ready=0, 6 putc events, FIFO_DEPTH=4 -> 4 queued, ev_dropped=2; release ready -> 4 events in order.
REQ-036 exit (32'h15000001) with 2 events queued, ev_ready=0 -> termination=0; later putc ignored; ready=1 -> 3 events drained then termination=1.
REQ-037 termination_all=4'b0111 -> all_done=0; 4'b1111 -> all_done=1 one cycle later.
REQ-038 rst_sys pulse with FIFO non-empty in DRAIN -> all outputs zero next cycle, ACTIVE resumes capturing.

Source files
------------

// File: rtl/nop_event_pkg.sv
// nop_event_pkg: shared event type, opcodes and state enum; OPTIMSOC_NOP_EVENT_TIMESTAMP_EN adds a timestamp field
package nop_event_pkg;
    localparam logic [15:0] NOP_OPCODE_HI = 16'h1500;
    localparam logic [15:0] NOP_EXIT      = 16'h0001;
    localparam logic [15:0] NOP_PUTC      = 16'h0004;
    typedef struct packed {
`ifdef OPTIMSOC_NOP_EVENT_TIMESTAMP_EN
        logic [31:0] timestamp;
`endif
        logic [15:0] id;
        logic [31:0] value;
        logic [31:0] pc;
        logic        supv;
    } nop_event_t;
    typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} nop_state_e;
endpackage

// File: rtl/nop_event_fifo.sv
// nop_event_fifo: power-of-two event FIFO, pointers carry one extra wrap bit for full/empty
module nop_event_fifo
    import nop_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  nop_event_t data_i,
    output nop_event_t data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, rd_q;
    nop_event_t  mem_q [DEPTH];
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    // advance pointers; caller never pops empty nor pushes full without a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end
    // storage needs no reset: empty masks the output
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/nop_event_capture.sv
// nop_event_capture: captures l.nop 0x15xx events into a FIFO, drains on exit; OPTIMSOC_NOP_EVENT_TIMESTAMP_EN adds timestamps
module nop_event_capture
    import nop_event_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TERM_CROSS_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst_sys,
    input  logic                      enable,
    input  logic [31:0]               wb_pc,
    input  logic [31:0]               wb_insn,
    input  logic [31:0]               r3,
    input  logic                      supv,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output nop_event_t                ev_data,
    output logic [15:0]               ev_dropped,
    output logic                      termination,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic                      all_done
);
    nop_state_e  state_q, state_d;
    nop_event_t  det_ev, hold_q, hold_d, fifo_din;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] dropped_q, dropped_d;
    logic        all_done_q;
    logic        detect, is_exit, accept, can_push, push, pop, full, empty;
`ifdef OPTIMSOC_NOP_EVENT_TIMESTAMP_EN
    logic [31:0] ts_q;
    // free-running cycle counter, wraps
    always_ff @(posedge clk) begin
        if (rst_sys) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end
`endif
    assign detect   = enable && (wb_insn[31:16] == NOP_OPCODE_HI) && (wb_insn[15:0] != 16'h0);
    assign is_exit  = wb_insn[15:0] == NOP_EXIT;
    assign accept   = (state_q == ACTIVE) && detect;
    assign pop      = ev_valid && ev_ready;
    assign can_push = !full || pop;
    // assemble the event seen this cycle
    always_comb begin
        det_ev       = '0;
        det_ev.id    = wb_insn[15:0];
        det_ev.value = r3;
        det_ev.pc    = wb_pc;
        det_ev.supv  = supv;
`ifdef OPTIMSOC_NOP_EVENT_TIMESTAMP_EN
        det_ev.timestamp = ts_q;
`endif
    end
    // next state: enqueue, drop, park exit in holding register, drain and finish
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        dropped_d    = dropped_q;
        push         = 1'b0;
        fifo_din     = det_ev;
        if (accept) begin
            push = can_push;
            if (!can_push && is_exit) begin
                hold_valid_d = 1'b1;
                hold_d       = det_ev;
            end
            if (!can_push && !is_exit && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            if (is_exit) state_d = DRAIN;
        end else if (hold_valid_q && can_push) begin
            push         = 1'b1;
            fifo_din     = hold_q;
            hold_valid_d = 1'b0;
        end
        if (state_q == DRAIN && empty && !hold_valid_q) state_d = DONE;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state_q      <= ACTIVE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            dropped_q    <= '0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            dropped_q    <= dropped_d;
            all_done_q   <= &termination_all;
        end
    end
    nop_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst_sys),
        .push_i (push),
        .pop_i  (pop),
        .data_i (fifo_din),
        .data_o (ev_data),
        .full_o (full),
        .empty_o(empty)
    );
    assign ev_valid    = !empty;
    assign ev_dropped  = dropped_q;
    assign termination = state_q == DONE;
    assign all_done    = all_done_q;
endmodule
